// File: rtl/vending_credit_if.sv
// vending_credit_if: coin inputs and dispense/change/credit outputs of the vending controller
interface vending_credit_if #(parameter int CREDIT_W = 6);
  logic five;
  logic ten;
  logic cancel;
  logic done;
  logic change;
  logic busy;
  logic [CREDIT_W-1:0] credit;
  modport master (output five, ten, cancel, input done, change, busy, credit);
  modport slave (input five, ten, cancel, output done, change, busy, credit);
endinterface

// File: rtl/vending_credit.sv
// vending_credit: credit-accumulating vending controller with timed dispense, refund and multi-unit change
module vending_credit #(
  parameter int PRICE = 15,
  parameter int COIN_LO = 5,
  parameter int COIN_HI = 10,
  parameter int CHANGE_UNIT = 5,
  parameter int HOLD_CYCLES = 8,
  parameter int CREDIT_W = 6
) (
  input logic clk,
  input logic reset,
  vending_credit_if.slave bus
);
  localparam int CNT_W = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CREDIT_W:0] PRICE_S = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0] LO_S = (CREDIT_W+1)'(COIN_LO);
  localparam logic [CREDIT_W:0] HI_S = (CREDIT_W+1)'(COIN_HI);
  localparam logic [CREDIT_W-1:0] UNIT = CREDIT_W'(CHANGE_UNIT);
  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;
  state_t state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CREDIT_W:0] sum;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      credit_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      cnt_q <= cnt_d;
    end
  end
  // five wins over ten when both arrive; cancel wins over any coin
  always_comb begin
    state_d = state_q;
    credit_d = credit_q;
    cnt_d = cnt_q;
    sum = {1'b0, credit_q} + (bus.five ? LO_S : HI_S);
    case (state_q)
      COLLECT: begin
        if (bus.cancel) begin
          if (credit_q != '0) state_d = CHANGE;
        end else if (bus.five || bus.ten) begin
          if (sum >= PRICE_S) begin
            state_d = VEND;
            credit_d = CREDIT_W'(sum - PRICE_S);
            cnt_d = '0;
          end else begin
            credit_d = sum[CREDIT_W-1:0];
          end
        end
      end
      VEND: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HOLD_LAST) begin
          state_d = credit_q >= UNIT ? CHANGE : COLLECT;
          credit_d = credit_q >= UNIT ? credit_q : '0;
        end
      end
      CHANGE: begin
        state_d = credit_q <= UNIT ? COLLECT : CHANGE;
        credit_d = credit_q <= UNIT ? '0 : credit_q - UNIT;
      end
      default: begin
        state_d = COLLECT;
        credit_d = '0;
      end
    endcase
  end
  assign bus.done = state_q == VEND;
  assign bus.change = state_q == CHANGE;
  assign bus.busy = state_q != COLLECT;
  assign bus.credit = credit_q;
endmodule
